// File: rtl/fp_pkg.sv
// fp_pkg: shared fp32 type, fpu opcodes and helpers
package fp_pkg;
  typedef logic [31:0] fp32_t;
  localparam logic [1:0] FP_OP_ADD = 2'b00;
  localparam logic [1:0] FP_OP_SUB = 2'b01;
  localparam logic [1:0] FP_OP_DIV = 2'b10;
  localparam logic [1:0] FP_OP_MUL = 2'b11;
  localparam fp32_t FP_POS_ZERO = 32'h0000_0000;
  function automatic logic is_nan(input fp32_t x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction
endpackage

// File: rtl/fp_mac_sequencer.sv
// fp_mac_sequencer: drives a shared fpu with MUL then ADD per operand pair to form bias + sum(a*b)
module fp_mac_sequencer
  import fp_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int FPU_LAT = 1,
  parameter int RELU_EN = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [31:0]                    bias,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_a,
  input  logic [31:0]                    in_b,
  input  logic                           in_last,
  output logic [31:0]                    fpu_a,
  output logic [31:0]                    fpu_b,
  output logic [1:0]                     fpu_opcode,
  input  logic [31:0]                    fpu_o,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_data,
  output logic [$clog2(MAX_LEN+1)-1:0]   out_count,
  output logic                           out_err,
  output logic                           busy
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int WW = FPU_LAT > 0 ? $clog2(FPU_LAT + 1) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, MUL_WAIT, ADD_WAIT, DONE} state_t;
  state_t state, state_n;
  fp32_t acc;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic last_q, last_seen, accept, wdone;
  assign in_ready = state == FETCH;
  assign busy = state != IDLE;
  assign accept = in_ready & in_valid;
  assign wdone = wcnt == '0;
  function automatic fp32_t relu(input fp32_t x);
    return (RELU_EN != 0 && x[31] && !is_nan(x)) ? FP_POS_ZERO : x;
  endfunction
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start) state_n = FETCH;
      FETCH:    if (in_valid) state_n = MUL_WAIT;
      MUL_WAIT: if (wdone) state_n = ADD_WAIT;
      ADD_WAIT: if (wdone) state_n = last_q ? DONE : FETCH;
      DONE:     if (out_ready) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // the window result is latched on the edge that captures the final sum
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      wcnt       <= '0;
      last_q     <= 1'b0;
      last_seen  <= 1'b0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_opcode <= FP_OP_ADD;
      out_data   <= '0;
      out_count  <= '0;
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        acc       <= bias;
        cnt       <= '0;
        out_err   <= 1'b0;
        last_seen <= 1'b0;
      end
      if (accept) begin
        fpu_a      <= in_a;
        fpu_b      <= in_b;
        fpu_opcode <= FP_OP_MUL;
        last_q     <= in_last | (cnt == CW'(MAX_LEN - 1));
        last_seen  <= in_last;
        wcnt       <= WW'(FPU_LAT);
        cnt        <= cnt + 1'b1;
      end
      if ((state == MUL_WAIT || state == ADD_WAIT) && !wdone) wcnt <= wcnt - 1'b1;
      if (state == MUL_WAIT && wdone) begin
        fpu_a      <= acc;
        fpu_b      <= fpu_o;
        fpu_opcode <= FP_OP_ADD;
        wcnt       <= WW'(FPU_LAT);
      end
      if (state == ADD_WAIT && wdone) begin
        acc <= fpu_o;
        if (last_q) begin
          out_data  <= relu(fpu_o);
          out_count <= cnt;
          out_err   <= ~last_seen;
          out_valid <= 1'b1;
        end
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp_mac_sequencer.sv
// tb_fp_mac_sequencer: two sequencer instances (MAX_LEN=4/LAT=1/ReLU and MAX_LEN=16/LAT=2/raw),
// each fed by a behavioural fpu whose output is corrupted outside the expected sample cycles.
module tb_fp_mac_sequencer;
  logic clk = 1'b0, rst = 1'b1, corrupt_en = 1'b0;
  logic [1:0] start = '0, in_valid = '0, in_last = '0, out_ready = '0;
  logic [1:0] in_ready, out_valid, out_err, busy;
  logic [1:0][31:0] bias = '0, in_a = '0, in_b = '0;
  logic [1:0][31:0] fpu_a, fpu_b, fpu_o, out_data;
  logic [1:0][1:0] fpu_opcode;
  logic [1:0][4:0] out_count;
  int cmp = 0, errs = 0;
  logic [31:0] qa[$], qb[$];

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'h00) return $bitstoreal({x[31], 63'b0});
    e = (x[30:23] == 8'hff) ? 11'h7ff : 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d = $realtobits(r);
    logic [10:0] e = d[62:52];
    if (e == 11'h000) return {d[63], 31'b0};
    if (e == 11'h7ff) return {d[63], 8'hff, d[51:29] | {22'b0, |d[51:0]}};
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    real x = f2r(a);
    real y = f2r(b);
    return r2f(op == 2'b00 ? x + y : op == 2'b01 ? x - y : op == 2'b10 ? x / y : x * y);
  endfunction

  function automatic int p_max(input int s); return s == 0 ? 4 : 16; endfunction
  function automatic int p_lat(input int s); return s == 0 ? 1 : 2; endfunction

  // Reference: bias plus the in-order sum of fp32-rounded products, then optional ReLU
  function automatic logic [31:0] ref_window(input int s, input logic [31:0] bv);
    logic [31:0] acc = bv;
    foreach (qa[i]) acc = r2f(f2r(acc) + f2r(r2f(f2r(qa[i]) * f2r(qb[i]))));
    return (s == 0 && acc[31] && !(acc[30:23] == 8'hff && acc[22:0] != 0)) ? 32'h0 : acc;
  endfunction

  function automatic logic [31:0] rv();
    return r2f((real'($urandom_range(16)) - 8.0) / 2.0);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int ML = g == 0 ? 4 : 16;
    localparam int FL = g == 0 ? 1 : 2;
    localparam int RE = g == 0 ? 1 : 0;
    logic [$clog2(ML+1)-1:0] oc;
    logic [31:0] pipe [FL];
    int since = 0;
    fp_mac_sequencer #(.MAX_LEN(ML), .FPU_LAT(FL), .RELU_EN(RE)) dut (
      .clk(clk), .rst(rst), .start(start[g]), .bias(bias[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_a(in_a[g]), .in_b(in_b[g]), .in_last(in_last[g]),
      .fpu_a(fpu_a[g]), .fpu_b(fpu_b[g]), .fpu_opcode(fpu_opcode[g]), .fpu_o(fpu_o[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
      .out_count(oc), .out_err(out_err[g]), .busy(busy[g])
    );
    assign out_count[g] = 5'(oc);
    always @(posedge clk) begin
      pipe[0] <= fpu_calc(fpu_opcode[g], fpu_a[g], fpu_b[g]);
      for (int i = 1; i < FL; i++) pipe[i] <= pipe[i-1];
      since <= (in_valid[g] && in_ready[g]) ? 1 : since + 1;
    end
    // only the MUL and ADD sample cycles after an accept see a genuine result
    assign fpu_o[g] = (corrupt_en && since != FL + 1 && since != 2 * FL + 2) ? 32'hC2F6E979 : pipe[FL-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_window(input int s, input logic [31:0] bv);
    bias[s] = bv;
    start[s] = 1'b1;
    tick();
    start[s] = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  task automatic feed(input int s, input logic [31:0] a, input logic [31:0] b, input bit last, output bit ok);
    ok = 1'b0;
    in_valid[s] = 1'b1;
    in_a[s] = a;
    in_b[s] = b;
    in_last[s] = last;
    for (int k = 0; k < 40 && !out_valid[s]; k++) begin
      if (in_ready[s]) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid[s] = 1'b0;
    in_last[s] = 1'b0;
    if (ok) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endtask

  task automatic wait_out(input int s);
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (out_valid[s]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    cmp++;
    if (!ok) begin
      errs++;
      $display("FAIL wait_out[%0d]: out_valid=%b, required 1 within 60 cycles", s, out_valid[s]);
    end
  endtask

  task automatic handshake(input int s);
    out_ready[s] = 1'b1;
    tick();
    out_ready[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      cmp++;
      if ({busy[s], out_valid[s], in_ready[s], out_err[s], fpu_opcode[s], out_count[s]} !== 11'h0) begin
        errs++;
        $display("FAIL reset_ctrl[%0d]: busy=%b ov=%b ir=%b err=%b op=%b cnt=%0d, required all 0", s,
                 busy[s], out_valid[s], in_ready[s], out_err[s], fpu_opcode[s], out_count[s]);
      end
      cmp++;
      if ({fpu_a[s], fpu_b[s], out_data[s]} !== 96'h0) begin
        errs++;
        $display("FAIL reset_data[%0d]: a=%h b=%h out=%h, required 0", s, fpu_a[s], fpu_b[s], out_data[s]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_dot_basic();
    bit ok0, ok1;
    for (int s = 0; s < 2; s++) begin
      begin_window(s, 32'h0);
      feed(s, 32'h3F800000, 32'h40000000, 1'b0, ok0);
      feed(s, 32'h40400000, 32'h3F000000, 1'b1, ok1);
      wait_out(s);
      cmp++;
      if ({ok0, ok1, out_data[s], out_count[s], out_err[s]} !== {2'b11, 32'h40600000, 5'd2, 1'b0}) begin
        errs++;
        $display("FAIL basic[%0d]: acc=%b%b data=%h cnt=%0d err=%b, required 11 40600000 2 0", s,
                 ok0, ok1, out_data[s], out_count[s], out_err[s]);
      end
      cmp++;
      if (out_data[s] !== ref_window(s, 32'h0)) begin
        errs++;
        $display("FAIL basic_ref[%0d]: data=%h, required %h", s, out_data[s], ref_window(s, 32'h0));
      end
      handshake(s);
      cmp++;
      if ({busy[s], out_valid[s]} !== 2'b00) begin
        errs++;
        $display("FAIL basic_release[%0d]: busy=%b ov=%b, required 0 0", s, busy[s], out_valid[s]);
      end
    end
  endtask

  task automatic test_relu();
    bit ok;
    logic [31:0] exp_d;
    for (int s = 0; s < 2; s++) begin
      begin_window(s, 32'h3F800000);
      feed(s, 32'hBF800000, 32'h40000000, 1'b1, ok);
      wait_out(s);
      exp_d = s == 0 ? 32'h00000000 : 32'hBF800000;
      cmp++;
      if (out_data[s] !== exp_d) begin
        errs++;
        $display("FAIL relu[%0d]: data=%h, required %h", s, out_data[s], exp_d);
      end
      handshake(s);
    end
  endtask

  task automatic test_issue_timing();
    bit ok;
    logic [31:0] a, b, bv;
    for (int s = 0; s < 2; s++) begin
      a = rv();
      b = rv();
      bv = rv();
      begin_window(s, bv);
      feed(s, a, b, 1'b1, ok);
      cmp++;
      if ({ok, fpu_opcode[s], fpu_a[s], fpu_b[s]} !== {1'b1, 2'b11, a, b}) begin
        errs++;
        $display("FAIL issue_mul[%0d]: acc=%b op=%b a=%h b=%h, required 1 11 %h %h", s, ok, fpu_opcode[s], fpu_a[s], fpu_b[s], a, b);
      end
      repeat (p_lat(s)) tick();
      cmp++;
      if (fpu_opcode[s] !== 2'b11) begin
        errs++;
        $display("FAIL issue_hold[%0d]: op=%b, required 11", s, fpu_opcode[s]);
      end
      tick();
      cmp++;
      if ({fpu_opcode[s], fpu_a[s], fpu_b[s]} !== {2'b00, bv, r2f(f2r(a) * f2r(b))}) begin
        errs++;
        $display("FAIL issue_add[%0d]: op=%b a=%h b=%h, required 00 %h %h", s, fpu_opcode[s], fpu_a[s], fpu_b[s], bv, r2f(f2r(a) * f2r(b)));
      end
      wait_out(s);
      cmp++;
      if (out_data[s] !== ref_window(s, bv)) begin
        errs++;
        $display("FAIL issue_result[%0d]: data=%h, required %h", s, out_data[s], ref_window(s, bv));
      end
      handshake(s);
    end
  endtask

  task automatic test_cutoff();
    bit ok;
    int n = 0;
    begin_window(0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      feed(0, 32'h3F800000, 32'h3F800000, 1'b0, ok);
      n += int'(ok);
    end
    wait_out(0);
    cmp++;
    if (n != 4 || in_ready[0] !== 1'b0) begin
      errs++;
      $display("FAIL cutoff_accepts: accepted=%0d in_ready=%b, required 4 0", n, in_ready[0]);
    end
    cmp++;
    if ({out_data[0], out_count[0], out_err[0]} !== {32'h40800000, 5'd4, 1'b1}) begin
      errs++;
      $display("FAIL cutoff_result: data=%h cnt=%0d err=%b, required 40800000 4 1", out_data[0], out_count[0], out_err[0]);
    end
    handshake(0);
  endtask

  task automatic test_reset_mid();
    bit ok0, ok1;
    for (int s = 0; s < 2; s++) begin
      begin_window(s, 32'h0);
      feed(s, 32'h3F800000, 32'h40000000, 1'b0, ok0);
      repeat (p_lat(s) + 1) tick();
      rst = 1'b1;
      tick();
      cmp++;
      if ({busy[s], out_valid[s], in_ready[s], fpu_opcode[s]} !== 5'b0) begin
        errs++;
        $display("FAIL reset_mid[%0d]: busy=%b ov=%b ir=%b op=%b, required 0", s, busy[s], out_valid[s], in_ready[s], fpu_opcode[s]);
      end
      rst = 1'b0;
      begin_window(s, 32'h0);
      feed(s, 32'h3F800000, 32'h40000000, 1'b0, ok0);
      feed(s, 32'h40400000, 32'h3F000000, 1'b1, ok1);
      wait_out(s);
      cmp++;
      if ({out_data[s], out_count[s], out_err[s]} !== {32'h40600000, 5'd2, 1'b0}) begin
        errs++;
        $display("FAIL reset_rerun[%0d]: data=%h cnt=%0d err=%b, required 40600000 2 0", s, out_data[s], out_count[s], out_err[s]);
      end
      handshake(s);
    end
  endtask

  task automatic test_hold();
    bit ok;
    logic [31:0] d0, bv;
    bv = rv();
    begin_window(1, bv);
    feed(1, rv(), rv(), 1'b1, ok);
    wait_out(1);
    d0 = out_data[1];
    for (int k = 0; k < 5; k++) begin
      start[1] = k == 2;
      tick();
      cmp++;
      if ({out_data[1], busy[1], out_valid[1]} !== {d0, 2'b11}) begin
        errs++;
        $display("FAIL hold[%0d]: data=%h busy=%b ov=%b, required %h 1 1", k, out_data[1], busy[1], out_valid[1], d0);
      end
    end
    start[1] = 1'b1;
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    cmp++;
    if ({busy[1], out_valid[1]} !== 2'b00) begin
      errs++;
      $display("FAIL hold_start_ignored: busy=%b ov=%b, required 0 0", busy[1], out_valid[1]);
    end
    tick();
    start[1] = 1'b0;
    cmp++;
    if ({busy[1], in_ready[1]} !== 2'b11) begin
      errs++;
      $display("FAIL hold_next_start: busy=%b ir=%b, required 1 1", busy[1], in_ready[1]);
    end
    qa.delete();
    qb.delete();
    feed(1, rv(), rv(), 1'b1, ok);
    wait_out(1);
    cmp++;
    if (out_data[1] !== ref_window(1, bv)) begin
      errs++;
      $display("FAIL hold_rerun: data=%h, required %h", out_data[1], ref_window(1, bv));
    end
    handshake(1);
  endtask

  task automatic test_random();
    bit ok, last, exp_err;
    int n, acc_n, exp_n;
    logic [31:0] bv;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 25; w++) begin
        bv = rv();
        n = $urandom_range(p_max(s) + 2, 1);
        last = n < p_max(s) ? 1'b1 : 1'($urandom % 2);
        exp_n = n < p_max(s) ? n : p_max(s);
        exp_err = !(last && n <= p_max(s));
        begin_window(s, bv);
        acc_n = 0;
        for (int i = 0; i < n; i++) begin
          if ($urandom % 3 == 0) tick();
          feed(s, rv(), rv(), last && i == n - 1, ok);
          acc_n += int'(ok);
        end
        wait_out(s);
        cmp++;
        if (acc_n != exp_n || out_count[s] != 5'(exp_n) || out_err[s] !== exp_err) begin
          errs++;
          $display("FAIL rand_count[%0d/%0d]: accepted=%0d cnt=%0d err=%b, required %0d %0d %b", s, w,
                   acc_n, out_count[s], out_err[s], exp_n, exp_n, exp_err);
        end
        cmp++;
        if (out_data[s] !== ref_window(s, bv)) begin
          errs++;
          $display("FAIL rand_data[%0d/%0d]: data=%h, required %h", s, w, out_data[s], ref_window(s, bv));
        end
        repeat ($urandom % 4) tick();
        handshake(s);
      end
    end
  endtask

  initial begin
    corrupt_en = 1'b1;
    test_reset();
    test_dot_basic();
    test_relu();
    test_issue_timing();
    test_cutoff();
    test_reset_mid();
    test_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
